// File: rtl/mux_rr_nto1_reg.sv
// N-to-1 round-robin multiplexer with valid/ready on every port and one registered output stage.
// A forced-select mode bypasses the round-robin search without moving the pointer.
module mux_rr_nto1_reg #(
    parameter  int WIDTH = 32,
    parameter  int N_IN  = 4,
    localparam int SEL_W = (N_IN > 2) ? $clog2(N_IN) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_IN-1:0]         i_valid,
    input  logic [N_IN*WIDTH-1:0]   i_data,
    output logic [N_IN-1:0]         o_ready,
    input  logic                    i_force_en,
    input  logic [SEL_W-1:0]        i_force_sel,
    output logic                    o_valid,
    output logic [WIDTH-1:0]        o_data,
    output logic [SEL_W-1:0]        o_sel,
    input  logic                    i_ready
);

    logic [SEL_W-1:0] ptr;
    logic             accept;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W:0]   rr_sum;
    logic [SEL_W-1:0] rr_idx;
    logic             load;
    logic [WIDTH-1:0] chan_data;

    // Gated by reset so no producer sees an accept while the block is held in reset.
    assign accept = i_rst_n && (!o_valid || i_ready);

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_sum    = '0;
        rr_idx    = '0;
        if (i_force_en) begin
            if (int'(i_force_sel) < N_IN) begin
                grant_vld = i_valid[i_force_sel];
                grant_idx = i_force_sel;
            end
        end else begin
            // Search ptr, ptr+1, ... with an explicit wrap so non-power-of-two N_IN stays in range.
            for (int unsigned j = 0; j < N_IN; j++) begin
                rr_sum = {1'b0, ptr} + (SEL_W+1)'(j);
                if (rr_sum >= (SEL_W+1)'(N_IN))
                    rr_sum = rr_sum - (SEL_W+1)'(N_IN);
                rr_idx = rr_sum[SEL_W-1:0];
                if (!grant_vld && i_valid[rr_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = rr_idx;
                end
            end
        end
    end

    assign load      = accept && grant_vld;
    assign o_ready   = load ? (N_IN'(1) << grant_idx) : '0;
    assign chan_data = i_data[grant_idx*WIDTH +: WIDTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sel   <= '0;
            ptr     <= '0;
        end else begin
            if (load) begin
                o_valid <= 1'b1;
                o_data  <= chan_data;
                o_sel   <= grant_idx;
                if (!i_force_en)
                    ptr <= (grant_idx == SEL_W'(N_IN-1)) ? '0 : grant_idx + 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_nto1_reg.sv
// Bench for mux_rr_nto1_reg: a 4-input and a 3-input instance checked against a
// behavioural model, with directed steps followed by randomized traffic.
module tb_mux_rr_nto1_reg;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   valid_s    [2];
    logic [127:0] data_s     [2];
    logic         force_en_s [2];
    logic [1:0]   force_sel_s[2];
    logic         ready_s    [2];

    logic [3:0]  rdy4;
    logic        ov4;
    logic [31:0] od4;
    logic [1:0]  osel4;
    logic [2:0]  rdy3;
    logic        ov3;
    logic [31:0] od3;
    logic [1:0]  osel3;

    always #5 clk = ~clk;

    mux_rr_nto1_reg #(.WIDTH(32), .N_IN(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_valid(valid_s[0]), .i_data(data_s[0]), .o_ready(rdy4),
        .i_force_en(force_en_s[0]), .i_force_sel(force_sel_s[0]),
        .o_valid(ov4), .o_data(od4), .o_sel(osel4), .i_ready(ready_s[0])
    );

    mux_rr_nto1_reg #(.WIDTH(32), .N_IN(3)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_valid(valid_s[1][2:0]), .i_data(data_s[1][95:0]), .o_ready(rdy3),
        .i_force_en(force_en_s[1]), .i_force_sel(force_sel_s[1]),
        .o_valid(ov3), .o_data(od3), .o_sel(osel3), .i_ready(ready_s[1])
    );

    int          nch[2] = '{4, 3};
    int          m_ptr[2];
    bit          m_ov[2];
    logic [31:0] m_od[2];
    int          m_osel[2];
    int          last_g[2];
    logic [3:0]  last_rdy[2];
    int          total = 0;
    int          passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int exp_grant(int d);
        int n = nch[d];
        if (force_en_s[d]) begin
            int s = int'(force_sel_s[d]);
            if (s < n && valid_s[d][s]) return s;
            return -1;
        end
        for (int j = 0; j < n; j++) begin
            int k = (m_ptr[d] + j) % n;
            if (valid_s[d][k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready(int d);
        int g = exp_grant(d);
        if (rst_n && (!m_ov[d] || ready_s[d]) && g >= 0) return 4'(1) << g;
        return 4'b0;
    endfunction

    function automatic logic [3:0]  obs_ready(int d); return (d == 0) ? rdy4 : {1'b0, rdy3}; endfunction
    function automatic logic        obs_valid(int d); return (d == 0) ? ov4 : ov3; endfunction
    function automatic logic [31:0] obs_data(int d);  return (d == 0) ? od4 : od3; endfunction
    function automatic logic [1:0]  obs_sel(int d);   return (d == 0) ? osel4 : osel3; endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0; m_ov[d] = 1'b0; m_od[d] = '0; m_osel[d] = 0; last_g[d] = -1;
        end
    endtask

    // One clock: check both instances against the model, advance the model, cross the edge.
    task automatic step();
        #1;
        for (int d = 0; d < 2; d++) begin
            last_rdy[d] = obs_ready(d);
            chk($sformatf("d%0d_ready", d), 32'(obs_ready(d)), 32'(exp_ready(d)));
            chk($sformatf("d%0d_valid", d), 32'(obs_valid(d)), 32'(m_ov[d]));
            chk($sformatf("d%0d_data", d), obs_data(d), m_od[d]);
            chk($sformatf("d%0d_sel", d), 32'(obs_sel(d)), 32'(m_osel[d]));
        end
        for (int d = 0; d < 2; d++) begin
            int g = exp_grant(d);
            last_g[d] = -1;
            if ((!m_ov[d] || ready_s[d]) && g >= 0) begin
                last_g[d] = g;
                m_ov[d]   = 1'b1;
                m_od[d]   = data_s[d][g*32 +: 32];
                m_osel[d] = g;
                if (!force_en_s[d]) m_ptr[d] = (g + 1) % nch[d];
            end else if (m_ov[d] && ready_s[d]) begin
                m_ov[d] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] held_data;

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            valid_s[d] = 4'b1111; data_s[d] = {$urandom, $urandom, $urandom, $urandom};
            force_en_s[d] = 1'b0; force_sel_s[d] = '0; ready_s[d] = 1'b1;
        end
        valid_s[1][3] = 1'b0;
        model_reset();
        #3;
        chk("rst_ready", 32'(rdy4), 32'h0);
        chk("rst_valid", 32'(ov4), 32'h0);
        chk("rst_data", od4, 32'h0);
        chk("rst_sel", 32'(osel4), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request on channel 2, 3-input instance under full contention alongside.
        valid_s[0] = 4'b0100;
        data_s[0][95:64] = 32'hDEADBEEF;
        step();
        chk("single_ready", 32'(last_rdy[0]), 32'h4);
        chk("single_valid", 32'(ov4), 32'h1);
        chk("single_data", od4, 32'hDEADBEEF);
        chk("single_sel", 32'(osel4), 32'h2);
        chk("n3_grant0", 32'(last_rdy[1]), 32'h1);

        valid_s[0] = 4'b1111;
        step();
        chk("ptr_after_single", 32'(last_rdy[0]), 32'h8);
        chk("n3_grant1", 32'(last_rdy[1]), 32'h2);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("contention_grant", 32'(last_rdy[0]), 32'(1 << (i % 4)));
            chk("contention_valid", 32'(ov4), 32'h1);
            chk("n3_wrap_grant", 32'(last_rdy[1]), 32'(1 << ((i + 2) % 3)));
            chk("n3_sel_range", 32'(osel3 != 2'd3), 32'h1);
        end

        // Backpressure: held beat must not move and nothing is accepted.
        ready_s[0] = 1'b0;
        held_data = od4;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_ready", 32'(last_rdy[0]), 32'h0);
            chk("bp_data_stable", od4, held_data);
            chk("bp_sel_stable", 32'(osel4), 32'h1);
        end
        ready_s[0] = 1'b1;
        step();
        chk("bp_release_grant", 32'(last_rdy[0]), 32'h4);
        chk("bp_release_sel", 32'(osel4), 32'h2);

        // Forced select on channel 1; pointer must stay at 3.
        force_en_s[0] = 1'b1; force_sel_s[0] = 2'd1; valid_s[0] = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("force_grant", 32'(last_rdy[0]), 32'h2);
            chk("force_sel", 32'(osel4), 32'h1);
        end
        valid_s[0] = 4'b1001;
        step();
        chk("force_nogrant", 32'(last_rdy[0]), 32'h0);
        chk("force_drained", 32'(ov4), 32'h0);
        force_en_s[0] = 1'b0; valid_s[0] = 4'b1111;
        step();
        chk("force_ptr_kept", 32'(last_rdy[0]), 32'h8);

        // Randomized traffic honouring the hold-until-accepted producer rule.
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                ready_s[d] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 15) == 0) force_en_s[d] = ~force_en_s[d];
                if ($urandom_range(0, 7) == 0) force_sel_s[d] = 2'($urandom_range(0, 3));
                for (int k = 0; k < nch[d]; k++) begin
                    if (!valid_s[d][k] || last_g[d] == k) begin
                        valid_s[d][k] = $urandom_range(0, 1);
                        data_s[d][k*32 +: 32] = $urandom;
                    end
                end
            end
            step();
        end

        // Reset mid-operation with a held beat and ptr at 2.
        for (int d = 0; d < 2; d++) begin
            force_en_s[d] = 1'b0; ready_s[d] = 1'b1;
        end
        valid_s[0] = 4'b0010;
        step();
        chk("pre_reset_valid", 32'(ov4), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(ov4), 32'h0);
        chk("async_rst_data", od4, 32'h0);
        chk("async_rst_sel", 32'(osel4), 32'h0);
        chk("async_rst_ready", 32'(rdy4), 32'h0);
        model_reset();
        rst_n = 1'b1;
        valid_s[0] = 4'b1111;
        valid_s[1] = 4'b0111;
        step();
        chk("post_reset_grant", 32'(last_rdy[0]), 32'h1);
        chk("post_reset_grant_n3", 32'(last_rdy[1]), 32'h1);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
